hub75_scan_driver: RTL and testbench
====================================

HUB75_SCAN_DRIVER -- requirements
Module: hub75_scan_driver

Interface
REQ-001 Parameter COLS, default 64: columns per scan line (power of 2, at least 2).
REQ-002 Parameter ROW_BITS, default 4: row-address width; there are 2^ROW_BITS scan rows.
REQ-003 Parameter DEPTH, default 4: bit planes per colour (1..8).
REQ-004 Parameter DISP_BASE, default 8: display cycles for plane 0.
REQ-005 Parameter BLANK_CYC, default 2: blanking cycles (see Configuration).
REQ-006 clk  in  1  single clock; all logic on the rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  run scanning while high.
REQ-009 pix_rd  out  1  read strobe to the pixel store.
REQ-010 pix_addr  out  ROW_BITS+log2(COLS)  {row, col} read address.
REQ-011 pix_top, pix_bot  in  3*DEPTH each  {R,G,B} words for upper and lower half, valid the cycle after pix_rd.
REQ-012 addr  out  ROW_BITS  panel row select (A,B,C,D... order, LSB = A).
REQ-013 r0,g0,b0,r1,g1,b1  out  1 each  serial colour data (0 = upper half, 1 = lower half).
REQ-014 sclk  out  1  panel shift clock.
REQ-015 lat  out  1  latch pulse.
REQ-016 oe  out  1  output blank; high = LEDs off.
REQ-017 frame_done  out  1  one-cycle pulse at end of frame.
REQ-018 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-019 FSM states: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
REQ-020 IDLE -> SHIFT when enable=1; row=0, plane=0, col=0 on entry.
REQ-021 SHIFT uses 3 cycles per column: RD (pix_rd=1, pix_addr={row,col}), SETUP (register r0=pix_top[2*DEPTH+plane], g0=pix_top[DEPTH+plane], b0=pix_top[plane], same for r1/g1/b1 from pix_bot; sclk=0), CLK (sclk=1).
REQ-022 SHIFT lasts exactly 3*COLS cycles; oe=1 throughout; after CLK of col COLS-1 -> BLANK (or LATCH, see Configuration).
REQ-023 LATCH: exactly 1 cycle, lat=1, oe=1; addr updates to the current row at LATCH entry and is otherwise stable.
REQ-024 DISPLAY: oe=0 for exactly DISP_BASE<<plane cycles, lat=0, sclk=0.
REQ-025 DISPLAY end: if plane<DEPTH-1, plane increments; otherwise plane=0 and row increments, wrapping modulo 2^ROW_BITS.
REQ-026 frame_done=1 in the last DISPLAY cycle of plane DEPTH-1 of row 2^ROW_BITS-1.
REQ-027 DISPLAY end with enable=1 -> SHIFT; with enable=0 -> IDLE, oe=1, counters cleared.
REQ-028 enable dropping in SHIFT/BLANK/LATCH does not abort; the current plane completes through DISPLAY.
REQ-029 Counter widths: col log2(COLS) bits, plane log2(DEPTH)+1 bits, display counter wide enough for DISP_BASE<<(DEPTH-1); no overflow permitted.
REQ-030 pix_rd is high only in RD cycles; pix_addr holds its last value otherwise.

Reset
REQ-031 rst_n low, asynchronous: state=IDLE; row, plane, col and display counters = 0.
REQ-032 Reset output values: oe=1, lat=0, sclk=0, colour outputs=0, addr=0, pix_rd=0, frame_done=0, busy=0.
REQ-033 Reset asserted mid-frame takes effect immediately; after release, scanning restarts at row 0, plane 0.

Configuration
REQ-034 Macro HUB75_BLANK_EN defined: SHIFT -> BLANK; BLANK holds oe=1, lat=0 for BLANK_CYC cycles, then -> LATCH (anti-ghosting dead time).
REQ-035 HUB75_BLANK_EN undefined: no BLANK state; SHIFT -> LATCH directly; BLANK_CYC is unused.

Verification (COLS=4, ROW_BITS=1, DEPTH=2, DISP_BASE=2, macro undefined unless stated)
REQ-036 Reset, then enable=1 -> busy rises 1 cycle later; 4 sclk rising edges, spaced 3 cycles apart; lat high 1 cycle at cycle 13 after SHIFT entry; oe low for 2 cycles, then for 4 cycles on plane 1.
REQ-037 pix_top=6'b10_01_11 (R=2,G=1,B=3) at all addresses -> plane 0: r0=0, g0=1, b0=1; plane 1: r0=1, g0=0, b0=1.
REQ-038 Continuous enable -> frame_done pulses every 64 cycles (2 rows x (15+17)); addr toggles 0,1,0.
REQ-039 enable dropped during SHIFT of row 1 plane 0 -> that plane's display completes, then IDLE with oe=1, busy=0; re-enabling restarts at addr=0.
REQ-040 rst_n pulsed low during DISPLAY -> oe=1 and busy=0 in the same cycle; HUB75_BLANK_EN defined with BLANK_CYC=2 -> row period becomes 17/19 cycles and frame_done spacing becomes 72 cycles.

Source files
------------

// File: rtl/hub75_scan_driver.sv
// HUB75 LED panel scan driver: shifts one bit plane per row, latches it, then shows it for DISP_BASE<<plane cycles.
// Optional macro HUB75_BLANK_EN adds BLANK_CYC dead cycles between the shift and the latch.
//
// state     | meaning
// S_IDLE    | panel blanked, counters cleared, waiting for enable
// S_SHIFT   | RD/SETUP/CLK triplet per column, oe high
// S_BLANK   | dead time before latch (HUB75_BLANK_EN only)
// S_LATCH   | one-cycle latch pulse, row address presented
// S_DISPLAY | LEDs on for the weight of the current plane
module hub75_scan_driver #(
    parameter int COLS      = 64,
    parameter int ROW_BITS  = 4,
    parameter int DEPTH     = 4,
    parameter int DISP_BASE = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    output logic                              pix_rd,
    output logic [ROW_BITS+$clog2(COLS)-1:0]  pix_addr,
    input  logic [3*DEPTH-1:0]                pix_top,
    input  logic [3*DEPTH-1:0]                pix_bot,
    output logic [ROW_BITS-1:0]               addr,
    output logic                              r0,
    output logic                              g0,
    output logic                              b0,
    output logic                              r1,
    output logic                              g1,
    output logic                              b1,
    output logic                              sclk,
    output logic                              lat,
    output logic                              oe,
    output logic                              frame_done,
    output logic                              busy
);

    localparam int COL_W    = $clog2(COLS);
    localparam int AW       = ROW_BITS + COL_W;
    localparam int PL_W     = $clog2(DEPTH) + 1;
    localparam int DISP_MAX = DISP_BASE << (DEPTH - 1);
    localparam int CNT_MAX  = (BLANK_CYC > DISP_MAX) ? BLANK_CYC : DISP_MAX;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [1:0] PH_RD    = 2'd0;
    localparam logic [1:0] PH_SETUP = 2'd1;
    localparam logic [1:0] PH_CLK   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
`ifdef HUB75_BLANK_EN
        S_BLANK,
`endif
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_phase;
    logic [COL_W-1:0]    r_col;
    logic [ROW_BITS-1:0] r_row;
    logic [PL_W-1:0]     r_plane;
    logic [CNT_W-1:0]    r_cnt;
    logic [ROW_BITS-1:0] r_addr;
    logic [AW-1:0]       r_addr_hold;
    logic [5:0]          r_rgb;

    logic                w_col_last;
    logic                w_plane_last;
    logic                w_row_last;
    logic                w_cnt_zero;
    logic [AW-1:0]       w_rd_addr;
    logic [CNT_W-1:0]    w_disp_load;
    logic [DEPTH-1:0]    w_tr, w_tg, w_tb, w_br, w_bg, w_bb;

    assign w_col_last   = (r_col == COL_W'(COLS - 1));
    assign w_plane_last = (r_plane == PL_W'(DEPTH - 1));
    assign w_row_last   = &r_row;
    assign w_cnt_zero   = (r_cnt == '0);
    assign w_rd_addr    = {r_row, r_col};
    assign w_disp_load  = (CNT_W'(DISP_BASE) << r_plane) - CNT_W'(1);

    // Shift each colour's plane field down so bit 0 is the current plane.
    assign w_tr = pix_top[2*DEPTH +: DEPTH] >> r_plane;
    assign w_tg = pix_top[DEPTH   +: DEPTH] >> r_plane;
    assign w_tb = pix_top[0       +: DEPTH] >> r_plane;
    assign w_br = pix_bot[2*DEPTH +: DEPTH] >> r_plane;
    assign w_bg = pix_bot[DEPTH   +: DEPTH] >> r_plane;
    assign w_bb = pix_bot[0       +: DEPTH] >> r_plane;

    assign busy     = (r_state != S_IDLE);
    assign addr     = r_addr;
    assign pix_addr = pix_rd ? w_rd_addr : r_addr_hold;
    assign {r0, g0, b0, r1, g1, b1} = r_rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        pix_rd     = 1'b0;
        sclk       = 1'b0;
        lat        = 1'b0;
        oe         = 1'b1;
        frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                pix_rd = (r_phase == PH_RD);
                sclk   = (r_phase == PH_CLK);
                if ((r_phase == PH_CLK) && w_col_last) begin
`ifdef HUB75_BLANK_EN
                    w_next = S_BLANK;
`else
                    w_next = S_LATCH;
`endif
                end
            end
`ifdef HUB75_BLANK_EN
            S_BLANK: begin
                if (w_cnt_zero) w_next = S_LATCH;
            end
`endif
            S_LATCH: begin
                lat    = 1'b1;
                w_next = S_DISPLAY;
            end
            S_DISPLAY: begin
                oe = 1'b0;
                if (w_cnt_zero) begin
                    frame_done = w_plane_last && w_row_last;
                    w_next     = enable ? S_SHIFT : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= PH_RD;
            r_col       <= '0;
            r_row       <= '0;
            r_plane     <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_addr_hold <= '0;
            r_rgb       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_phase <= PH_RD;
                    r_col   <= '0;
                    r_row   <= '0;
                    r_plane <= '0;
                    r_cnt   <= '0;
                end
                S_SHIFT: begin
                    case (r_phase)
                        PH_RD: begin
                            r_addr_hold <= w_rd_addr;
                            r_phase     <= PH_SETUP;
                        end
                        PH_SETUP: begin
                            r_rgb   <= {w_tr[0], w_tg[0], w_tb[0], w_br[0], w_bg[0], w_bb[0]};
                            r_phase <= PH_CLK;
                        end
                        default: begin
                            r_phase <= PH_RD;
                            r_col   <= r_col + COL_W'(1);
                        end
                    endcase
`ifdef HUB75_BLANK_EN
                    r_cnt <= CNT_W'(BLANK_CYC - 1);
`endif
                    if (w_next == S_LATCH) r_addr <= r_row;
                end
`ifdef HUB75_BLANK_EN
                S_BLANK: begin
                    if (!w_cnt_zero) r_cnt <= r_cnt - CNT_W'(1);
                    if (w_next == S_LATCH) r_addr <= r_row;
                end
`endif
                S_LATCH: begin
                    r_cnt <= w_disp_load;
                end
                S_DISPLAY: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (!enable) begin
                        r_row   <= '0;
                        r_plane <= '0;
                    end else if (w_plane_last) begin
                        r_plane <= '0;
                        r_row   <= r_row + ROW_BITS'(1);
                    end else begin
                        r_plane <= r_plane + PL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver (COLS=4, ROW_BITS=1, DEPTH=2, DISP_BASE=2) with a serial-data scoreboard.
module tb_hub75_scan_driver;

    localparam int BL    = `ifdef HUB75_BLANK_EN 2 `else 0 `endif ;
    localparam int FRAME = 64 + 4*BL;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       pix_rd;
    logic [2:0] pix_addr;
    logic [5:0] pix_top = '0;
    logic [5:0] pix_bot = '0;
    logic [0:0] addr;
    logic       r0, g0, b0, r1, g1, b1, sclk, lat, oe, frame_done, busy;

    hub75_scan_driver #(
        .COLS(4), .ROW_BITS(1), .DEPTH(2), .DISP_BASE(2), .BLANK_CYC(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_top(pix_top), .pix_bot(pix_bot),
        .addr(addr), .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
        .sclk(sclk), .lat(lat), .oe(oe), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    int mode = 0;

    logic [5:0] ser_q[$];
    int addr_q[$];
    int sclk_t[$], lat_t[$], fd_t[$], oe_run[$];
    int run = 0;
    int rd_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] word(input int m, input logic [2:0] a);
        return (m == 0) ? 6'b10_01_11 : {a, a};
    endfunction

    function automatic logic [5:0] exp_ser(input int m, input int row, input int col, input int p);
        logic [2:0] a;
        logic [5:0] t, b;
        a = {row[0], col[1:0]};
        t = word(m, a);
        b = ~t;
        return {t[4+p], t[2+p], t[p], b[4+p], b[2+p], b[p]};
    endfunction

    // Pixel store: data returned the cycle after the read strobe.
    always @(posedge clk) begin
        if (pix_rd) begin
            pix_top <= word(mode, pix_addr);
            pix_bot <= ~word(mode, pix_addr);
        end
    end

    always @(negedge clk) begin
        if (sclk) begin
            sclk_t.push_back(cyc);
            chk("ser_q_nonempty", ser_q.size() != 0, 1);
            if (ser_q.size() != 0) chk("serial", {r0, g0, b0, r1, g1, b1}, ser_q.pop_front());
        end
        if (lat) begin
            lat_t.push_back(cyc);
            chk("addr_q_nonempty", addr_q.size() != 0, 1);
            if (addr_q.size() != 0) chk("lat_addr", addr, addr_q.pop_front());
        end
        if (frame_done) fd_t.push_back(cyc);
        if (pix_rd) rd_cnt++;
        if (!oe) run++;
        else if (run > 0) begin
            oe_run.push_back(run);
            run = 0;
        end
    end

    task automatic clear_logs();
        ser_q.delete(); addr_q.delete();
        sclk_t.delete(); lat_t.delete(); fd_t.delete(); oe_run.delete();
        run = 0;
        rd_cnt = 0;
    endtask

    task automatic push_planes(input int n);
        for (int k = 0; k < n; k++) begin
            addr_q.push_back((k / 2) % 2);
            for (int c = 0; c < 4; c++) ser_q.push_back(exp_ser(mode, (k / 2) % 2, c, k % 2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int t0, start, found;
        repeat (3) @(negedge clk);
        chk("rst_oe", oe, 1);
        chk("rst_lat", lat, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_rgb", {r0, g0, b0, r1, g1, b1}, 0);
        chk("rst_addr", addr, 0);
        chk("rst_pix_rd", pix_rd, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Continuous scanning, then enable drops in the SHIFT of row 1 plane 0 of frame 3.
        clear_logs();
        mode = 0;
        push_planes(11);
        enable = 1'b1;
        t0 = cyc;
        chk("busy_same_cycle", busy, 0);
        @(negedge clk);
        chk("busy_rise", busy, 1);
        start = t0 + 2*FRAME + 1 + 32 + 2*BL;
        while (cyc < start + 3) @(negedge clk);
        enable = 1'b0;
        while (cyc < start + 14 + BL) @(negedge clk);
        chk("last_disp_busy", busy, 1);
        chk("last_disp_oe", oe, 0);
        @(negedge clk);
        chk("stop_busy", busy, 0);
        chk("stop_oe", oe, 1);
        repeat (5) @(negedge clk);
        chk("stays_idle", busy, 0);
        chk("sclk0", sclk_t[0] - t0, 3);
        chk("sclk1", sclk_t[1] - t0, 6);
        chk("sclk2", sclk_t[2] - t0, 9);
        chk("sclk3", sclk_t[3] - t0, 12);
        chk("sclk_count", sclk_t.size(), 44);
        chk("rd_count", rd_cnt, 44);
        chk("lat0", lat_t[0] - t0, 13 + BL);
        chk("lat_spacing", lat_t[1] - lat_t[0], 15 + BL);
        chk("lat_count", lat_t.size(), 11);
        chk("oe_run0", oe_run[0], 2);
        chk("oe_run1", oe_run[1], 4);
        chk("fd_count", fd_t.size(), 2);
        chk("fd0", fd_t[0] - t0, FRAME);
        chk("fd_spacing", fd_t[1] - fd_t[0], FRAME);
        chk("a_ser_drained", ser_q.size(), 0);
        chk("a_addr_drained", addr_q.size(), 0);

        // One address-dependent frame, restarting from row 0 after the earlier stop.
        clear_logs();
        mode = 1;
        push_planes(4);
        enable = 1'b1;
        t0 = cyc;
        found = 0;
        for (int i = 0; i < 3*FRAME && found == 0; i++) begin
            @(negedge clk);
            if (frame_done) found = 1;
        end
        chk("fd_wait", found, 1);
        enable = 1'b0;
        @(negedge clk);
        chk("b_idle", busy, 0);
        chk("b_fd", fd_t[0] - t0, FRAME);
        chk("b_lat_count", lat_t.size(), 4);
        chk("b_ser_drained", ser_q.size(), 0);

        // Reset during row 1 display, then scanning must resume at row 0 plane 0.
        clear_logs();
        push_planes(3);
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 3*FRAME && found == 0; i++) begin
            @(negedge clk);
            if (!oe && addr == 1'b1) found = 1;
        end
        chk("row1_disp_wait", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", oe, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", addr, 0);
        chk("c_ser_drained", ser_q.size(), 0);
        push_planes(1);
        @(negedge clk);
        rst_n = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (!oe) found = 1;
        end
        chk("restart_disp_wait", found, 1);
        enable = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (!busy) found = 1;
        end
        chk("restart_idle_wait", found, 1);
        chk("c_lat_count", lat_t.size(), 4);
        chk("c_ser_final", ser_q.size(), 0);
        chk("c_addr_final", addr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
